// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the matrix-keypad scanner.
//   - kp_state_t    : scanner FSM state encoding
//   - KP_*_DEF      : default parameter values for keypad_scanner
//   - onehot_count  : population count, used to tell a single pressed row
//                     from an idle matrix or a ghosting multi-key pattern
package keypad_pkg;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_PRESSED  = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

    localparam int KP_ROWS_DEF     = 4;
    localparam int KP_COLS_DEF     = 4;
    localparam int KP_DWELL_DEF    = 4;
    localparam int KP_DEBOUNCE_DEF = 8;

    // Counts set bits in a vector of up to 32 rows (callers zero-extend).
    function automatic logic [5:0] onehot_count(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
//   Two-flop synchroniser for a bus of independent asynchronous levels.
//   Each bit is synchronised on its own; no cross-bit coherency is implied.
// Ports:
//   clk_i  : destination clock
//   rst_i  : asynchronous, active-high reset (clears both stages)
//   d_i    : asynchronous input levels
//   q_o    : synchronised levels, two clk_i edges of latency
module keypad_sync
    import keypad_pkg::*;
#(
    parameter int WIDTH = KP_ROWS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix-keypad scanner: strobes one column at a time, samples the
//   synchronised row returns at the end of each column dwell, debounces a
//   single-row hit, and reports it once as a keyvalid pulse. Multi-row hits
//   are treated as ghosting and skipped. No rollover: a new key is only
//   accepted after the current one has fully released.
// Ports:
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   readrow  : raw row returns (active-high, asynchronous)
//   scancol  : one-hot column drive
//   keycode  : {row one-hot, col one-hot} of the last accepted key (sticky)
//   keyidx   : row*COLS+col of the last accepted key (sticky)
//   keyvalid : one-cycle pulse when a press has been debounced
//   keyheld  : high while the accepted key is pressed or releasing
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = KP_ROWS_DEF,
    parameter int COLS     = KP_COLS_DEF,
    parameter int DWELL    = KP_DWELL_DEF,
    parameter int DEBOUNCE = KP_DEBOUNCE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ROWS-1:0]               readrow,
    output logic [COLS-1:0]               scancol,
    output logic [ROWS+COLS-1:0]          keycode,
    output logic [$clog2(ROWS*COLS)-1:0]  keyidx,
    output logic                          keyvalid,
    output logic                          keyheld
);

    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int KW   = $clog2(ROWS*COLS);
    localparam int DW_W = $clog2(DWELL);
    localparam int DB_W = $clog2(DEBOUNCE);

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);

    logic [ROWS-1:0]      rows_s;

    kp_state_t            state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [DW_W-1:0]      dwell_q, dwell_d;
    logic [DB_W-1:0]      db_q, db_d;
    logic [ROWS-1:0]      row_cap_q, row_cap_d;
    logic [ROWS+COLS-1:0] keycode_q, keycode_d;
    logic [KW-1:0]        keyidx_q, keyidx_d;
    logic                 keyvalid_q, keyvalid_d;

    logic                 single_row;
    logic [CW-1:0]        next_col;
    logic [RW-1:0]        row_idx;

    keypad_sync #(
        .WIDTH (ROWS)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (readrow),
        .q_o   (rows_s)
    );

    // Exactly one row asserted; zero rows is idle, two or more is ghosting.
    assign single_row = (onehot_count(32'(rows_s)) == 6'd1);
    assign next_col   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

    always_comb begin
        scancol = '0;
        for (int c = 0; c < COLS; c++) begin
            scancol[c] = (col_q == CW'(c));
        end
    end

    // row_cap_q is one-hot whenever it is used, so a priority scan suffices.
    always_comb begin
        row_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_cap_q[r]) begin
                row_idx = RW'(r);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dwell_d    = dwell_q;
        db_d       = db_q;
        row_cap_d  = row_cap_q;
        keycode_d  = keycode_q;
        keyidx_d   = keyidx_q;
        keyvalid_d = 1'b0;

        case (state_q)
            KP_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_row) begin
                        // Column stays frozen from here until release completes.
                        state_d   = KP_DEBOUNCE;
                        row_cap_d = rows_s;
                        db_d      = '0;
                    end else begin
                        col_d = next_col;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            KP_DEBOUNCE: begin
                if (rows_s == row_cap_q) begin
                    if (db_q == DB_LAST) begin
                        state_d    = KP_PRESSED;
                        keyvalid_d = 1'b1;
                        keycode_d  = {row_cap_q, scancol};
                        keyidx_d   = KW'(int'(row_idx) * COLS + int'(col_q));
                        db_d       = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    // Bounce or glitch: rescan the same column from scratch.
                    state_d = KP_SCAN;
                    dwell_d = '0;
                    db_d    = '0;
                end
            end

            KP_PRESSED: begin
                if (rows_s != row_cap_q) begin
                    state_d = KP_RELEASE;
                    db_d    = '0;
                end
            end

            KP_RELEASE: begin
                if (rows_s == row_cap_q) begin
                    // Release chatter: key is back, resume holding without a new pulse.
                    state_d = KP_PRESSED;
                    db_d    = '0;
                end else if (rows_s != '0) begin
                    db_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = KP_SCAN;
                    col_d   = next_col;
                    dwell_d = '0;
                    db_d    = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end

            default: begin
                state_d = KP_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= KP_SCAN;
            col_q      <= '0;
            dwell_q    <= '0;
            db_q       <= '0;
            row_cap_q  <= '0;
            keycode_q  <= '0;
            keyidx_q   <= '0;
            keyvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            db_q       <= db_d;
            row_cap_q  <= row_cap_d;
            keycode_q  <= keycode_d;
            keyidx_q   <= keyidx_d;
            keyvalid_q <= keyvalid_d;
        end
    end

    assign keycode  = keycode_q;
    assign keyidx   = keyidx_q;
    assign keyvalid = keyvalid_q;
    assign keyheld  = (state_q == KP_PRESSED) || (state_q == KP_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner at default parameters. A keypad
//   matrix model turns the pressed-key map and scancol into readrow. Each
//   press that should be reported pushes its expected code/index into a
//   queue; a monitor pops and compares on every keyvalid pulse and flags
//   any pulse nobody asked for.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] readrow;
    logic [3:0] scancol;
    logic [7:0] keycode;
    logic [3:0] keyidx;
    logic       keyvalid;
    logic       keyheld;

    keypad_scanner #(
        .ROWS     (4),
        .COLS     (4),
        .DWELL    (4),
        .DEBOUNCE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .readrow  (readrow),
        .scancol  (scancol),
        .keycode  (keycode),
        .keyidx   (keyidx),
        .keyvalid (keyvalid),
        .keyheld  (keyheld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: pressed[row][col]; a row returns high when its key's column is strobed.
    logic [3:0][3:0] pressed;
    logic [3:0]      glitch;
    logic [3:0]      model_rows;

    always_comb begin
        model_rows = '0;
        for (int r = 0; r < 4; r++) begin
            model_rows[r] = |(pressed[r] & scancol);
        end
    end
    assign readrow = model_rows | glitch;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        int         row;
        int         col;
        bit         bouncy;
        logic [7:0] code;
        logic [3:0] idx;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   pulse_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard side: every keyvalid cycle must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && keyvalid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_keyvalid", 32'(keycode), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_keycode", 32'(keycode), 32'(e.code));
                chk("pulse_keyidx", 32'(keyidx), 32'(e.idx));
            end
        end
    end

    task automatic wait_pulse(input int base, input int budget, input string name);
        int n;
        n = 0;
        while (pulse_cnt == base && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(pulse_cnt - base), 32'd1);
    endtask

    task automatic wait_col(input logic [3:0] target, input string name);
        logic [3:0] prev;
        int         n;
        prev = scancol;
        n    = 0;
        tick();
        while (!(prev != target && scancol == target) && n < 40) begin
            prev = scancol;
            tick();
            n++;
        end
        chk(name, 32'(scancol), 32'(target));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (keyheld && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(keyheld), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_scancol"}, 32'(scancol), 32'h1);
        chk({tag, "_keycode"}, 32'(keycode), 32'h0);
        chk({tag, "_keyidx"}, 32'(keyidx), 32'h0);
        chk({tag, "_keyvalid"}, 32'(keyvalid), 32'h0);
        chk({tag, "_keyheld"}, 32'(keyheld), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [3];
        logic [3:0] exp_col;
        logic [3:0] seen;
        int         base;

        vecs[0] = '{row: 1, col: 1, bouncy: 1'b0, code: 8'b0010_0010, idx: 4'd5};
        vecs[1] = '{row: 3, col: 3, bouncy: 1'b1, code: 8'b1000_1000, idx: 4'd15};
        vecs[2] = '{row: 2, col: 0, bouncy: 1'b0, code: 8'b0100_0001, idx: 4'd8};

        rst     = 1'b1;
        pressed = '0;
        glitch  = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Idle rotation: 4 cycles per column.
        for (int k = 0; k <= 16; k++) begin
            exp_col = 4'(1 << ((k / 4) % 4));
            chk("idle_rotate", 32'(scancol), 32'(exp_col));
            tick();
        end

        // Single-key presses, clean or with bounce, then release.
        for (int i = 0; i < 3; i++) begin
            base = pulse_cnt;
            exp_q.push_back({vecs[i].code, vecs[i].idx});
            if (vecs[i].bouncy) begin
                for (int b = 0; b < 4; b++) begin
                    pressed[vecs[i].row][vecs[i].col] = (b % 2 == 0);
                    repeat (3) tick();
                end
            end
            pressed[vecs[i].row][vecs[i].col] = 1'b1;
            wait_pulse(base, 80, "press_pulse");
            repeat (70) tick();
            exp_col = 4'(1 << vecs[i].col);
            chk("hold_pulses", 32'(pulse_cnt - base), 32'd1);
            chk("hold_keyheld", 32'(keyheld), 32'd1);
            chk("hold_scancol", 32'(scancol), 32'(exp_col));
            chk("hold_keycode", 32'(keycode), 32'(vecs[i].code));
            chk("hold_keyidx", 32'(keyidx), 32'(vecs[i].idx));

            if (vecs[i].bouncy) begin
                for (int b = 0; b < 4; b++) begin
                    pressed[vecs[i].row][vecs[i].col] = (b % 2 == 1);
                    repeat (4) tick();
                end
            end
            // Final release: 2 sync edges, 1 edge into RELEASE, 8 debounce edges.
            pressed[vecs[i].row][vecs[i].col] = 1'b0;
            repeat (10) tick();
            chk("release_still_held", 32'(keyheld), 32'd1);
            tick();
            chk("release_done", 32'(keyheld), 32'd0);
            exp_col = 4'(1 << ((vecs[i].col + 1) % 4));
            chk("release_next_col", 32'(scancol), 32'(exp_col));
            chk("release_no_pulse", 32'(pulse_cnt - base), 32'd1);
        end

        // Ghosting: two rows on the same column are never accepted.
        base          = pulse_cnt;
        pressed[0][2] = 1'b1;
        pressed[2][2] = 1'b1;
        seen          = '0;
        repeat (40) begin
            tick();
            seen |= scancol;
        end
        chk("ghost_no_pulse", 32'(pulse_cnt - base), 32'd0);
        chk("ghost_rotating", 32'(seen), 32'hF);
        chk("ghost_keyheld", 32'(keyheld), 32'd0);
        exp_q.push_back({8'b0001_0100, 4'd2});
        pressed[2][2] = 1'b0;
        wait_pulse(base, 60, "ghost_resolve_pulse");
        tick();
        chk("ghost_resolve_keycode", 32'(keycode), 32'h14);
        chk("ghost_resolve_keyidx", 32'(keyidx), 32'd2);
        pressed[0][2] = 1'b0;
        wait_idle("ghost_release");

        // Short glitch on row1 during the column-0 dwell.
        base = pulse_cnt;
        wait_col(4'b0001, "glitch_align");
        glitch = 4'b0010;
        repeat (5) tick();
        glitch = 4'b0000;
        repeat (40) tick();
        chk("glitch_no_pulse", 32'(pulse_cnt - base), 32'd0);
        chk("glitch_keycode", 32'(keycode), 32'h14);
        chk("glitch_keyidx", 32'(keyidx), 32'd2);
        chk("glitch_keyheld", 32'(keyheld), 32'd0);

        // Reset while debouncing: capture happens 4 edges into the column-1 dwell.
        base = pulse_cnt;
        wait_col(4'b0010, "dbrst_align");
        pressed[1][1] = 1'b1;
        repeat (6) tick();
        chk("dbrst_frozen", 32'(scancol), 32'h2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("dbrst");
        pressed = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("dbrst_no_pulse", 32'(pulse_cnt - base), 32'd0);

        // Reset while pressed.
        base = pulse_cnt;
        exp_q.push_back({8'b0010_0010, 4'd5});
        pressed[1][1] = 1'b1;
        wait_pulse(base, 60, "prst_pulse");
        repeat (3) tick();
        chk("prst_keyheld", 32'(keyheld), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("prst");
        pressed = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("prst_no_pulse", 32'(pulse_cnt - base), 32'd1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
